// File: rtl/battle_attack_gen_if.sv
// Battle turn bus: keyboard/HP inputs towards the attack generator and hit/animation results back.
interface battle_attack_gen_if;
    logic       col_e;
    logic       boss;
    logic [7:0] key_in;
    logic       key_valid;
    logic [7:0] HP_player;
    logic [7:0] HP_enemy;
    logic [6:0] player_hit;
    logic [7:0] enemy_hit;
    logic       hit_valid;
    logic [2:0] p_attack;
    logic [2:0] e_attack;
    logic       battle_active;
    logic       battle_won;
    logic       battle_lost;

    modport master (
        output col_e, boss, key_in, key_valid, HP_player, HP_enemy,
        input  player_hit, enemy_hit, hit_valid, p_attack, e_attack,
               battle_active, battle_won, battle_lost
    );

    modport slave (
        input  col_e, boss, key_in, key_valid, HP_player, HP_enemy,
        output player_hit, enemy_hit, hit_valid, p_attack, e_attack,
               battle_active, battle_won, battle_lost
    );
endinterface

// File: rtl/battle_attack_gen.sv
// Turn-based battle sequencer: player key attacks, delayed enemy strikes, HP check and win/loss latch.
module battle_attack_gen #(
    parameter logic [15:0] DELAY_CYCLES = 16'd1000
) (
    input logic                clk_b,
    input logic                rst,
    battle_attack_gen_if.slave bus
);
    localparam logic [3:0] S_IDLE    = 4'd0;
    localparam logic [3:0] S_P_WAIT  = 4'd1;
    localparam logic [3:0] S_P_HIT   = 4'd2;
    localparam logic [3:0] S_E_DELAY = 4'd3;
    localparam logic [3:0] S_E_HIT   = 4'd4;
    localparam logic [3:0] S_SETTLE  = 4'd5;
    localparam logic [3:0] S_CHECK   = 4'd6;
    localparam logic [3:0] S_WON     = 4'd7;
    localparam logic [3:0] S_LOST    = 4'd8;

    localparam logic [7:0] KEY_LIGHT = 8'h1C;
    localparam logic [7:0] KEY_HEAVY = 8'h32;
    localparam logic [7:0] KEY_ACK   = 8'h5A;

    logic [3:0]  state, state_d;
    logic [7:0]  lfsr;
    logic [15:0] cnt, cnt_d;
    logic        boss_q, boss_q_d;
    logic        ret_enemy, ret_enemy_d;
    logic [6:0]  player_hit, player_hit_d;
    logic [7:0]  enemy_hit, enemy_hit_d;
    logic        hit_valid, hit_valid_d;
    logic [2:0]  p_attack, p_attack_d;
    logic [2:0]  e_attack, e_attack_d;
    logic        battle_active, battle_active_d;
    logic        battle_won, battle_won_d;
    logic        battle_lost, battle_lost_d;
    logic [6:0]  enemy_base_c;

    assign bus.player_hit    = player_hit;
    assign bus.enemy_hit     = enemy_hit;
    assign bus.hit_valid     = hit_valid;
    assign bus.p_attack      = p_attack;
    assign bus.e_attack      = e_attack;
    assign bus.battle_active = battle_active;
    assign bus.battle_won    = battle_won;
    assign bus.battle_lost   = battle_lost;

    // Base enemy damage 5..20; boss doubling is a left shift of this
    assign enemy_base_c = 7'd5 + 7'(lfsr[3:0]);

    always_ff @(posedge clk_b or posedge rst) begin
        if (rst) begin
            state         <= S_IDLE;
            lfsr          <= 8'hA5;
            cnt           <= 16'd0;
            boss_q        <= 1'b0;
            ret_enemy     <= 1'b0;
            player_hit    <= 7'd0;
            enemy_hit     <= 8'd0;
            hit_valid     <= 1'b0;
            p_attack      <= 3'd0;
            e_attack      <= 3'd0;
            battle_active <= 1'b0;
            battle_won    <= 1'b0;
            battle_lost   <= 1'b0;
        end else begin
            state         <= state_d;
            lfsr          <= {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
            cnt           <= cnt_d;
            boss_q        <= boss_q_d;
            ret_enemy     <= ret_enemy_d;
            player_hit    <= player_hit_d;
            enemy_hit     <= enemy_hit_d;
            hit_valid     <= hit_valid_d;
            p_attack      <= p_attack_d;
            e_attack      <= e_attack_d;
            battle_active <= battle_active_d;
            battle_won    <= battle_won_d;
            battle_lost   <= battle_lost_d;
        end
    end

    always_comb begin
        state_d      = state;
        cnt_d        = 16'd0;
        boss_q_d     = boss_q;
        ret_enemy_d  = ret_enemy;
        player_hit_d = player_hit;
        enemy_hit_d  = enemy_hit;
        hit_valid_d  = 1'b0;
        p_attack_d   = p_attack;
        e_attack_d   = e_attack;
        battle_won_d = battle_won;
        battle_lost_d = battle_lost;

        case (state)
            S_IDLE: begin
                battle_won_d  = 1'b0;
                battle_lost_d = 1'b0;
                if (bus.col_e) begin
                    boss_q_d   = bus.boss;
                    p_attack_d = 3'd0;
                    e_attack_d = 3'd0;
                    state_d    = S_P_WAIT;
                end
            end
            S_P_WAIT: begin
                if (bus.key_valid && bus.key_in == KEY_LIGHT) begin
                    enemy_hit_d  = 8'd10 + 8'(lfsr[2:0]);
                    player_hit_d = 7'd0;
                    p_attack_d   = 3'd1;
                    hit_valid_d  = 1'b1;
                    state_d      = S_P_HIT;
                end else if (bus.key_valid && bus.key_in == KEY_HEAVY) begin
                    player_hit_d = 7'd0;
                    hit_valid_d  = 1'b1;
                    state_d      = S_P_HIT;
                    if (lfsr[7:6] == 2'b00) begin
                        enemy_hit_d = 8'd0;
                        p_attack_d  = 3'd3;
                    end else begin
                        enemy_hit_d = 8'd20 + 8'(lfsr[3:0]);
                        p_attack_d  = 3'd2;
                    end
                end
            end
            S_P_HIT: begin
                ret_enemy_d = 1'b0;
                state_d     = S_SETTLE;
            end
            S_E_DELAY: begin
                // Strike values load on the terminal count so they are valid with the E_HIT strobe
                if (cnt == 16'(DELAY_CYCLES - 16'd1)) begin
                    player_hit_d = boss_q ? {enemy_base_c[5:0], 1'b0} : enemy_base_c;
                    enemy_hit_d  = 8'd0;
                    e_attack_d   = 3'd1;
                    hit_valid_d  = 1'b1;
                    state_d      = S_E_HIT;
                end else begin
                    cnt_d = cnt + 16'd1;
                end
            end
            S_E_HIT: begin
                ret_enemy_d = 1'b1;
                state_d     = S_SETTLE;
            end
            S_SETTLE: begin
                state_d = S_CHECK;
            end
            S_CHECK: begin
                if (bus.HP_enemy == 8'd0) begin
                    battle_won_d = 1'b1;
                    state_d      = S_WON;
                end else if (bus.HP_player == 8'd0) begin
                    battle_lost_d = 1'b1;
                    state_d       = S_LOST;
                end else begin
                    p_attack_d = 3'd0;
                    e_attack_d = 3'd0;
                    state_d    = ret_enemy ? S_P_WAIT : S_E_DELAY;
                end
            end
            S_WON, S_LOST: begin
                if (bus.key_valid && bus.key_in == KEY_ACK) begin
                    battle_won_d  = 1'b0;
                    battle_lost_d = 1'b0;
                    state_d       = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        battle_active_d = (state_d != S_IDLE) && (state_d != S_WON) && (state_d != S_LOST);
    end
endmodule

// File: tb/tb_battle_attack_gen.sv
// Scoreboard bench for battle_attack_gen: expected strobes queued at key press, compared at each hit_valid.
module tb_battle_attack_gen;
    localparam int unsigned D = 8;

    typedef struct packed {
        logic [6:0] ph;
        logic [7:0] eh;
        logic [2:0] pa;
        logic [2:0] ea;
    } exp_t;

    logic clk_b = 1'b0;
    logic rst   = 1'b1;
    battle_attack_gen_if bus();

    battle_attack_gen #(.DELAY_CYCLES(16'(D))) dut (
        .clk_b (clk_b),
        .rst   (rst),
        .bus   (bus)
    );

    always #5 clk_b = ~clk_b;

    int   errors = 0;
    int   checks = 0;
    int   cyc    = 0;
    logic prev_hv = 1'b0;
    logic boss_exp = 1'b0;
    logic [7:0] m;
    exp_t sb[$];
    int   strobe_t[$];

    function automatic logic [7:0] step(input logic [7:0] l);
        return {l[6:0], l[7] ^ l[5] ^ l[4] ^ l[3]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference random source, reset and stepped alongside the design
    always @(posedge clk_b or posedge rst) begin
        if (rst) m <= 8'hA5;
        else     m <= step(m);
    end

    always @(posedge clk_b) cyc <= cyc + 1;

    always @(negedge clk_b) begin
        if (!rst && bus.hit_valid) begin
            exp_t e;
            chk("hv_consec", 32'(prev_hv), 32'd0);
            strobe_t.push_back(cyc);
            if (sb.size() == 0) begin
                chk("unexp_strobe", 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk("player_hit", 32'(bus.player_hit), 32'(e.ph));
                chk("enemy_hit",  32'(bus.enemy_hit),  32'(e.eh));
                chk("p_attack",   32'(bus.p_attack),   32'(e.pa));
                chk("e_attack",   32'(bus.e_attack),   32'(e.ea));
            end
        end
        prev_hv <= bus.hit_valid;
    end

    task automatic next_cyc();
        @(negedge clk_b);
        #1;
    endtask

    task automatic check_reset_outs(input string tag);
        chk({tag, "_ph"},  32'(bus.player_hit),    32'd0);
        chk({tag, "_eh"},  32'(bus.enemy_hit),     32'd0);
        chk({tag, "_hv"},  32'(bus.hit_valid),     32'd0);
        chk({tag, "_pa"},  32'(bus.p_attack),      32'd0);
        chk({tag, "_ea"},  32'(bus.e_attack),      32'd0);
        chk({tag, "_act"}, 32'(bus.battle_active), 32'd0);
        chk({tag, "_won"}, 32'(bus.battle_won),    32'd0);
        chk({tag, "_lost"},32'(bus.battle_lost),   32'd0);
    endtask

    task automatic start_battle(input logic b);
        next_cyc();
        bus.col_e = 1'b1;
        bus.boss  = b;
        boss_exp  = b;
        next_cyc();
        bus.col_e = 1'b0;
        bus.boss  = ~b;
        chk("start_active", 32'(bus.battle_active), 32'd1);
    endtask

    // Drive a key for one cycle; optionally queue the player strobe and the following enemy strobe
    task automatic press_key(input logic [7:0] k, input bit exp_player, input bit exp_enemy);
        logic [7:0] l;
        exp_t e;
        bus.key_in    = k;
        bus.key_valid = 1'b1;
        l = m;
        if (exp_player) begin
            e = '0;
            if (k == 8'h1C) begin
                e.eh = 8'd10 + 8'(l[2:0]);
                e.pa = 3'd1;
            end else if (l[7:6] == 2'b00) begin
                e.eh = 8'd0;
                e.pa = 3'd3;
            end else begin
                e.eh = 8'd20 + 8'(l[3:0]);
                e.pa = 3'd2;
            end
            sb.push_back(e);
        end
        if (exp_enemy) begin
            for (int i = 0; i < int'(D) + 3; i++) l = step(l);
            e = '0;
            e.ph = 7'd5 + 7'(l[3:0]);
            if (boss_exp) e.ph = e.ph * 7'd2;
            e.ea = 3'd1;
            sb.push_back(e);
        end
        next_cyc();
        bus.key_valid = 1'b0;
    endtask

    task automatic wait_hits(input int left);
        int n = 0;
        while (sb.size() > left && n < 200) begin
            next_cyc();
            n++;
        end
        if (sb.size() > left) begin
            chk("strobe_timeout", 32'(sb.size()), 32'(left));
            sb.delete();
        end
    endtask

    task automatic wait_lfsr(input bit want_miss);
        int n = 0;
        while (((m[7:6] == 2'b00) != want_miss) && n < 300) begin
            next_cyc();
            n++;
        end
        chk("lfsr_wait", 32'(m[7:6] == 2'b00), 32'(want_miss));
    endtask

    initial begin
        bus.col_e = 1'b0; bus.boss = 1'b0; bus.key_in = 8'h00; bus.key_valid = 1'b0;
        bus.HP_player = 8'd100; bus.HP_enemy = 8'd150;
        repeat (3) next_cyc();
        check_reset_outs("reset");
        rst = 1'b0;
        next_cyc();
        chk("idle_active", 32'(bus.battle_active), 32'd0);

        // Light attack, then an ignored key and col_e toggling during the enemy think time
        start_battle(1'b0);
        strobe_t.delete();
        press_key(8'h1C, 1'b1, 1'b1);
        wait_hits(1);
        repeat (3) next_cyc();
        bus.key_in = 8'h1C; bus.key_valid = 1'b1; bus.col_e = 1'b1;
        next_cyc();
        bus.key_valid = 1'b0; bus.col_e = 1'b0;
        next_cyc();
        bus.col_e = 1'b1;
        next_cyc();
        bus.col_e = 1'b0;
        wait_hits(0);
        if (strobe_t.size() == 2) chk("enemy_gap", 32'(strobe_t[1] - strobe_t[0]), 32'(D + 3));
        else chk("strobe_count", 32'(strobe_t.size()), 32'd2);
        repeat (3) next_cyc();
        chk("back_active", 32'(bus.battle_active), 32'd1);
        chk("back_pa", 32'(bus.p_attack), 32'd0);

        // Heavy hit, an unassigned key in P_WAIT, then heavy miss leading to a win with both HP zero
        next_cyc();
        wait_lfsr(1'b0);
        press_key(8'h32, 1'b1, 1'b1);
        wait_hits(0);
        repeat (3) next_cyc();
        press_key(8'h55, 1'b0, 1'b0);
        repeat (3) next_cyc();
        wait_lfsr(1'b1);
        press_key(8'h32, 1'b1, 1'b0);
        wait_hits(0);
        bus.HP_player = 8'd0; bus.HP_enemy = 8'd0;
        repeat (4) next_cyc();
        chk("win_won", 32'(bus.battle_won), 32'd1);
        chk("win_lost", 32'(bus.battle_lost), 32'd0);
        chk("win_active", 32'(bus.battle_active), 32'd0);
        press_key(8'h5A, 1'b0, 1'b0);
        chk("ack_won", 32'(bus.battle_won), 32'd0);
        chk("ack_active", 32'(bus.battle_active), 32'd0);
        bus.HP_player = 8'd100; bus.HP_enemy = 8'd150;

        // Boss battle: doubled enemy strike, then loss
        start_battle(1'b1);
        press_key(8'h1C, 1'b1, 1'b1);
        wait_hits(0);
        bus.HP_player = 8'd0;
        repeat (4) next_cyc();
        chk("lose_lost", 32'(bus.battle_lost), 32'd1);
        chk("lose_won", 32'(bus.battle_won), 32'd0);
        chk("lose_active", 32'(bus.battle_active), 32'd0);
        press_key(8'h5A, 1'b0, 1'b0);
        chk("ack_lost", 32'(bus.battle_lost), 32'd0);
        bus.HP_player = 8'd100;

        // Reset pulse while waiting for the enemy strike
        start_battle(1'b0);
        press_key(8'h1C, 1'b1, 1'b0);
        wait_hits(0);
        repeat (4) next_cyc();
        rst = 1'b1;
        #1;
        check_reset_outs("midrst");
        next_cyc();
        rst = 1'b0;
        press_key(8'h1C, 1'b0, 1'b0);
        repeat (30) next_cyc();
        chk("post_rst_active", 32'(bus.battle_active), 32'd0);
        chk("post_rst_queue", 32'(sb.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
